jk_reg_sequencer: RTL and testbench

JK_REG_SEQUENCER -- requirements
Module: jk_reg_sequencer

---
 rtl/jk_reg_sequencer.sv | 129 ++++++++++++
 tb/tb_jk_reg_sequencer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/jk_reg_sequencer.sv
// Command-driven sequencer over a bank of JK flip-flops: single-edge clear/set/toggle/load ops
// and multi-step synchronous counting. Define JKSEQ_SAT_EN to make counting saturate instead of wrap.
module jk_reg_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    input  logic [3:0]       cmd_cnt,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_dbg
);

    // Handshake: a command transfers on a rising edge where cmd_valid, cmd_ready and en are all 1;
    // cmd_ready is high only in IDLE, and a request made while busy is neither taken nor queued.

    localparam logic [2:0] OP_CLR  = 3'd1;
    localparam logic [2:0] OP_SET  = 3'd2;
    localparam logic [2:0] OP_TOG  = 3'd3;
    localparam logic [2:0] OP_LOAD = 3'd4;
    localparam logic [2:0] OP_UP   = 3'd5;
    localparam logic [2:0] OP_DN   = 3'd6;

    typedef enum logic [1:0] {IDLE, EXEC, COUNT, DONE} state_t;

    state_t           state, next_state;
    logic [2:0]       op_r;
    logic [WIDTH-1:0] data_r;
    logic [3:0]       cnt_r, cnt_next;
    logic [WIDTH-1:0] j, k;
    logic [WIDTH-1:0] tog_up, tog_dn;
    logic             accept;

    assign cmd_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign state_dbg = state;
    assign accept    = cmd_valid & cmd_ready & en;

    // Synchronous-counter toggle enables: bit i flips when all lower bits are 1 (up) or 0 (down).
    always_comb begin
        logic all_one, all_zero;
        tog_up   = '0;
        tog_dn   = '0;
        all_one  = 1'b1;
        all_zero = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tog_up[i] = all_one;
            tog_dn[i] = all_zero;
            all_one   = all_one & q[i];
            all_zero  = all_zero & ~q[i];
        end
    end

    always_comb begin
        next_state = state;
        j          = '0;
        k          = '0;
        cnt_next   = cnt_r;
        case (state)
            IDLE: begin
                if (accept)
                    next_state = (cmd_op == OP_UP || cmd_op == OP_DN) ? COUNT : EXEC;
            end
            EXEC: begin
                next_state = DONE;
                case (op_r)
                    OP_CLR:  k = '1;
                    OP_SET:  j = '1;
                    OP_TOG:  begin j = data_r; k = data_r;  end
                    OP_LOAD: begin j = data_r; k = ~data_r; end
                    default: ;
                endcase
            end
            COUNT: begin
                if (cnt_r == 4'd0) begin
                    next_state = DONE;
                end else begin
                    cnt_next = cnt_r - 4'd1;
                    if (cnt_r == 4'd1)
                        next_state = DONE;
`ifdef JKSEQ_SAT_EN
                    // Once pinned at the limit, the remaining steps hold q.
                    if (op_r == OP_UP && !(&q)) begin
                        j = tog_up; k = tog_up;
                    end else if (op_r == OP_DN && (|q)) begin
                        j = tog_dn; k = tog_dn;
                    end
`else
                    if (op_r == OP_UP) begin
                        j = tog_up; k = tog_up;
                    end else begin
                        j = tog_dn; k = tog_dn;
                    end
`endif
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            op_r   <= '0;
            data_r <= '0;
            cnt_r  <= '0;
            q      <= '0;
        end else if (en) begin
            state <= next_state;
            q     <= (j & ~q) | (~k & q);
            if (accept) begin
                op_r   <= cmd_op;
                data_r <= cmd_data;
                cnt_r  <= cmd_cnt;
            end else begin
                cnt_r  <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_jk_reg_sequencer.sv
// Bench for jk_reg_sequencer: directed vector table, hand-written corner sequences
// (en stall, busy request, mid-count reset) and random commands against an arithmetic model.
module tb_jk_reg_sequencer;
    localparam int W = 4;
`ifdef JKSEQ_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic         clk, rst, en, cmd_valid, cmd_ready, busy, done;
    logic [2:0]   cmd_op;
    logic [W-1:0] cmd_data, q;
    logic [3:0]   cmd_cnt;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] q_model;

    jk_reg_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .en(en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .cmd_cnt(cmd_cnt), .q(q),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // Clock and watchdog
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: arithmetic on the register value, not JK equations.
    function automatic logic [W-1:0] ref_next(input logic [2:0] op, input logic [W-1:0] qv,
                                              input logic [W-1:0] d, input logic [3:0] c);
        int mx, v;
        mx = (1 << W) - 1;
        v  = int'(qv);
        case (op)
            3'd1: v = 0;
            3'd2: v = mx;
            3'd3: v = int'(qv ^ d);
            3'd4: v = int'(d);
            3'd5: begin v = v + int'(c); if (SAT && v > mx) v = mx; end
            3'd6: begin v = v - int'(c); if (SAT && v < 0) v = 0; end
            default: ;
        endcase
        return W'(v);
    endfunction

    function automatic int exp_edges(input logic [2:0] op, input logic [3:0] c);
        if (op == 3'd5 || op == 3'd6) return (c == 4'd0) ? 1 : int'(c);
        return 1;
    endfunction

    // Issue one command from IDLE; en may be randomly dropped while the command runs.
    task automatic do_cmd(input logic [2:0] op, input logic [W-1:0] d, input logic [3:0] c,
                          input logic [W-1:0] q_exp, input bit rand_en);
        int edges, exp_e;
        bit seen;
        logic [W-1:0] q_prev;
        check("ready_before", cmd_ready, 1);
        en = 1'b1; cmd_valid = 1'b1; cmd_op = op; cmd_data = d; cmd_cnt = c;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op = 3'($urandom); cmd_data = W'($urandom); cmd_cnt = 4'($urandom);
        check("busy_after_accept", busy, 1);
        exp_e = exp_edges(op, c);
        edges = 0;
        seen  = 1'b0;
        for (int t = 0; t < 200 && !seen; t++) begin
            if (done) seen = 1'b1;
            else begin
                en = rand_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                q_prev = q;
                @(posedge clk);
                if (en) edges++;
                @(negedge clk);
                if (!en) check("frozen_q", q, q_prev);
            end
        end
        check("done_seen", seen, 1);
        check("done_latency", edges, exp_e);
        check("q_result", q, q_exp);
        en = 1'b1;
        @(posedge clk); @(negedge clk);
        check("done_one_cycle", done, 0);
        check("ready_after", cmd_ready, 1);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] d;
        logic [3:0]   c;
        logic [W-1:0] q_wrap;
        logic [W-1:0] q_sat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        vecs[0]  = '{3'd4, 4'b1010, 4'd0, 4'b1010, 4'b1010};
        vecs[1]  = '{3'd3, 4'b0110, 4'd0, 4'b1100, 4'b1100};
        vecs[2]  = '{3'd1, 4'b1111, 4'd0, 4'b0000, 4'b0000};
        vecs[3]  = '{3'd2, 4'b0000, 4'd0, 4'b1111, 4'b1111};
        vecs[4]  = '{3'd4, 4'b1101, 4'd0, 4'b1101, 4'b1101};
        vecs[5]  = '{3'd5, 4'b0000, 4'd5, 4'b0010, 4'b1111};
        vecs[6]  = '{3'd4, 4'b0001, 4'd0, 4'b0001, 4'b0001};
        vecs[7]  = '{3'd6, 4'b0000, 4'd3, 4'b1110, 4'b0000};
        vecs[8]  = '{3'd5, 4'b0000, 4'd0, 4'b1110, 4'b0000};
        vecs[9]  = '{3'd0, 4'b1111, 4'd0, 4'b1110, 4'b0000};
        vecs[10] = '{3'd7, 4'b1111, 4'd9, 4'b1110, 4'b0000};
        vecs[11] = '{3'd5, 4'b0000, 4'd1, 4'b1111, 4'b0001};
        vecs[12] = '{3'd5, 4'b0000, 4'd1, 4'b0000, 4'b0010};
        vecs[13] = '{3'd6, 4'b0000, 4'd1, 4'b1111, 4'b0001};

        rst = 1'b0; en = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_data = '0; cmd_cnt = '0;
        #1;
        check("reset_q", q, 0);
        check("reset_ready", cmd_ready, 1);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Directed vector table
        foreach (vecs[i])
            do_cmd(vecs[i].op, vecs[i].d, vecs[i].c, SAT ? vecs[i].q_sat : vecs[i].q_wrap, 1'b0);

        // Request held while busy is ignored until cmd_ready returns
        cmd_valid = 1'b1; cmd_op = 3'd4; cmd_data = 4'b1010; en = 1'b1;
        @(posedge clk); @(negedge clk);
        cmd_op = 3'd1;
        check("busy_req_busy", busy, 1);
        @(posedge clk); @(negedge clk);
        check("busy_req_q_exec", q, 4'b1010);
        check("busy_req_done", done, 1);
        @(posedge clk); @(negedge clk);
        check("busy_req_not_taken", q, 4'b1010);
        check("busy_req_ready", cmd_ready, 1);
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        check("busy_req_taken", busy, 1);
        @(posedge clk); @(negedge clk);
        check("busy_req_clear_q", q, 0);
        check("busy_req_clear_done", done, 1);
        @(posedge clk); @(negedge clk);

        // Reset during the second step of a six-step count
        do_cmd(3'd4, 4'b0101, 4'd0, 4'b0101, 1'b0);
        cmd_valid = 1'b1; cmd_op = 3'd5; cmd_cnt = 4'd6;
        @(posedge clk); @(negedge clk);
        cmd_valid = 1'b0;
        @(posedge clk); @(negedge clk);
        check("rst_mid_step1", q, 4'b0110);
        #2 rst = 1'b0;
        #1;
        check("rst_mid_q", q, 0);
        check("rst_mid_ready", cmd_ready, 1);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_done", done, 0);
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_mid_no_done", done, 0);
        do_cmd(3'd4, 4'b0011, 4'd0, 4'b0011, 1'b0);

        // Eight-step count with en dropped for three cycles after the third step
        begin
            int total;
            bit seen;
            logic [W-1:0] q_hold;
            cmd_valid = 1'b1; cmd_op = 3'd5; cmd_cnt = 4'd8;
            @(posedge clk); @(negedge clk);
            cmd_valid = 1'b0;
            repeat (3) begin @(posedge clk); @(negedge clk); end
            check("stall_pre_q", q, 4'b0110);
            en = 1'b0;
            q_hold = q;
            repeat (3) begin
                @(posedge clk); @(negedge clk);
                check("stall_frozen_q", q, q_hold);
                check("stall_no_done", done, 0);
            end
            en = 1'b1;
            total = 6;
            seen = 1'b0;
            for (int t = 0; t < 40 && !seen; t++) begin
                if (done) seen = 1'b1;
                else begin @(posedge clk); @(negedge clk); total++; end
            end
            check("stall_done_seen", seen, 1);
            check("stall_done_latency", total, 11);
            check("stall_q", q, 4'b1011);
            @(posedge clk); @(negedge clk);
        end
        q_model = 4'b1011;

        // Random commands with random en stalls
        for (int n = 0; n < 40; n++) begin
            logic [2:0]   op;
            logic [W-1:0] d;
            logic [3:0]   c;
            op = 3'($urandom_range(0, 7));
            d  = W'($urandom);
            c  = 4'($urandom_range(0, 15));
            q_model = ref_next(op, q_model, d, c);
            do_cmd(op, d, c, q_model, 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
